btn_debounce_multi: RTL and testbench



---
 rtl/btn_debounce_multi.sv | 151 +++++++++++++++
 tb/tb_btn_debounce_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: per-channel polarity fix, 2-flop sync,
// 4-state debounce FSM and hold timer producing long-press / auto-repeat pulses.
module btn_debounce_multi #(
  parameter int              NCH           = 7,
  parameter int              DB_CYCLES     = 1000000,
  parameter int              LONG_CYCLES   = 25000000,
  parameter int              REPEAT_CYCLES = 5000000,
  parameter logic [NCH-1:0]  ACTIVE_LOW    = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] btn,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] press_tick,
  output logic [NCH-1:0] release_tick,
  output logic [NCH-1:0] long_tick,
  output logic [NCH-1:0] repeat_tick
);

  localparam int MAX_AB = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
  localparam int MAXC   = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int TW     = $clog2(MAXC) + 1;

  localparam logic [TW-1:0] DB_LAST   = TW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] INC       = TW'(1);
  localparam bit            REP_EN    = (REPEAT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, DLY0, ONE, DLY1} state_t;

  logic [NCH-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn ^ ACTIVE_LOW;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t          state, state_nx;
    logic [TW-1:0]   db_t, db_t_nx, hold_t, hold_t_nx;
    logic            rep, rep_nx;
    logic            press_nx, rel_nx, long_nx, rpt_nx, lvl_nx;
    logic            lvl_q, press_q, rel_q, long_q, rpt_q;
    logic            s;

    assign s = sync2[g];

    always_comb begin
      state_nx  = state;
      db_t_nx   = db_t;
      hold_t_nx = hold_t;
      rep_nx    = rep;
      press_nx  = 1'b0;
      rel_nx    = 1'b0;
      long_nx   = 1'b0;
      rpt_nx    = 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state_nx = DLY0;
            db_t_nx  = '0;
          end
        end
        DLY0: begin
          if (!s) begin
            state_nx = IDLE;
          end else if (db_t == DB_LAST) begin
            state_nx  = ONE;
            press_nx  = 1'b1;
            hold_t_nx = '0;
            rep_nx    = 1'b0;
          end else begin
            db_t_nx = db_t + INC;
          end
        end
        ONE: begin
          // Hold timer advances on every ONE cycle, including the one leaving for DLY1.
          if (!rep) begin
            if (hold_t == LONG_LAST) begin
              long_nx   = 1'b1;
              hold_t_nx = '0;
              rep_nx    = 1'b1;
            end else begin
              hold_t_nx = hold_t + INC;
            end
          end else if (REP_EN) begin
            if (hold_t == REP_LAST) begin
              rpt_nx    = 1'b1;
              hold_t_nx = '0;
            end else begin
              hold_t_nx = hold_t + INC;
            end
          end
          if (!s) begin
            state_nx = DLY1;
            db_t_nx  = '0;
          end
        end
        DLY1: begin
          if (s) begin
            state_nx = ONE;
          end else if (db_t == DB_LAST) begin
            state_nx = IDLE;
            rel_nx   = 1'b1;
          end else begin
            db_t_nx = db_t + INC;
          end
        end
        default: state_nx = IDLE;
      endcase
      lvl_nx = (state_nx == ONE) || (state_nx == DLY1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        db_t    <= '0;
        hold_t  <= '0;
        rep     <= 1'b0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        state   <= state_nx;
        db_t    <= db_t_nx;
        hold_t  <= hold_t_nx;
        rep     <= rep_nx;
        lvl_q   <= lvl_nx;
        press_q <= press_nx;
        rel_q   <= rel_nx;
        long_q  <= long_nx;
        rpt_q   <= rpt_nx;
      end
    end

    assign db_level[g]     = lvl_q;
    assign press_tick[g]   = press_q;
    assign release_tick[g] = rel_q;
    assign long_tick[g]    = long_q;
    assign repeat_tick[g]  = rpt_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: vector table plus hand sequences for
// the no-repeat build and reset during a repeat train.
module tb_btn_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn;
  logic [1:0] db_level, press_tick, release_tick, long_tick, repeat_tick;
  logic [0:0] btn_nr;
  logic [0:0] lvl_nr, press_nr, rel_nr, long_nr, rpt_nr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  prev_lvl;

  btn_debounce_multi #(
    .NCH(2), .DB_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW(2'b10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .db_level(db_level), .press_tick(press_tick), .release_tick(release_tick),
    .long_tick(long_tick), .repeat_tick(repeat_tick)
  );

  btn_debounce_multi #(
    .NCH(1), .DB_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn(btn_nr),
    .db_level(lvl_nr), .press_tick(press_nr), .release_tick(rel_nr),
    .long_tick(long_nr), .repeat_tick(rpt_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  btn;
    int unsigned n;
    logic [1:0]  lvl;
    logic [1:0]  press;
    logic [1:0]  rel;
    logic [1:0]  lng;
    logic [1:0]  rpt;
  } vec_t;

  vec_t tbl[$];
  vec_t rst_pre[$];
  vec_t rst_post[$];

  function automatic vec_t mk(logic [1:0] b, int unsigned n, logic [1:0] lvl,
                              logic [1:0] pr, logic [1:0] rl, logic [1:0] lg, logic [1:0] rp);
    vec_t v;
    v.btn = b; v.n = n; v.lvl = lvl; v.press = pr; v.rel = rl; v.lng = lg; v.rpt = rp;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned step, input int unsigned e,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d edge %0d: got %0h want %0h", name, step, e, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Events are only expected on the last edge of a step; earlier edges must be quiet.
  task automatic run_vec(input vec_t v, input int unsigned idx);
    btn = v.btn;
    for (int unsigned e = 1; e <= v.n; e++) begin
      tick();
      if (e < v.n) begin
        chk("quiet", idx, e, {24'd0, press_tick, release_tick, long_tick, repeat_tick}, 32'd0);
        chk("lvl_mid", idx, e, {30'd0, db_level}, {30'd0, prev_lvl});
      end else begin
        chk("lvl", idx, e, {30'd0, db_level}, {30'd0, v.lvl});
        chk("press", idx, e, {30'd0, press_tick}, {30'd0, v.press});
        chk("release", idx, e, {30'd0, release_tick}, {30'd0, v.rel});
        chk("long", idx, e, {30'd0, long_tick}, {30'd0, v.lng});
        chk("repeat", idx, e, {30'd0, repeat_tick}, {30'd0, v.rpt});
      end
    end
    prev_lvl = v.lvl;
  endtask

  initial begin
    // settle
    tbl.push_back(mk(2'b10,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // clean press, long, two repeats, release
    tbl.push_back(mk(2'b11, 11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 19, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(2'b11,  5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b11,  5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b10, 11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // glitches of 5 and 8 cycles rejected; 9 cycles accepted
    tbl.push_back(mk(2'b11,  5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11,  8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11,  9, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  2, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  9, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // 5-cycle release bounce: no release, long delayed by 5 (edge 36)
    tbl.push_back(mk(2'b11, 11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 19, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(2'b11,  5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b11,  5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b10, 11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // both channels together, channel 1 active-low
    tbl.push_back(mk(2'b01, 11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01,  1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 19, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(2'b01,  5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, 11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    rst_pre.push_back(mk(2'b11, 11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    rst_pre.push_back(mk(2'b11,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    rst_pre.push_back(mk(2'b11, 19, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    rst_pre.push_back(mk(2'b11,  5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    rst_post.push_back(mk(2'b11, 11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    rst_post.push_back(mk(2'b11,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    rst_post.push_back(mk(2'b10, 11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    rst_post.push_back(mk(2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    rst_n    = 1'b0;
    btn      = 2'b10;
    btn_nr   = 1'b0;
    prev_lvl = 2'b00;
    #2;
    chk("reset_outs", 0, 0, {22'd0, db_level, press_tick, release_tick, long_tick, repeat_tick}, 32'd0);
    tick(); tick(); tick();
    chk("reset_held", 0, 3, {22'd0, db_level, press_tick, release_tick, long_tick, repeat_tick}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // no-repeat build: single long_tick, then silence until release
    btn_nr = 1'b1;
    for (int unsigned e = 1; e <= 60; e++) begin
      tick();
      chk("nr_press", 100, e, {31'd0, press_nr}, {31'd0, (e == 11)});
      chk("nr_long", 100, e, {31'd0, long_nr}, {31'd0, (e == 31)});
      chk("nr_repeat", 100, e, {31'd0, rpt_nr}, 32'd0);
      chk("nr_lvl", 100, e, {31'd0, lvl_nr}, {31'd0, (e >= 11)});
    end
    btn_nr = 1'b0;
    for (int unsigned e = 1; e <= 12; e++) begin
      tick();
      chk("nr_release", 101, e, {31'd0, rel_nr}, {31'd0, (e == 11)});
      chk("nr_lvl_rel", 101, e, {31'd0, lvl_nr}, {31'd0, (e < 11)});
      chk("nr_quiet", 101, e, {29'd0, press_nr, long_nr, rpt_nr}, 32'd0);
    end

    // reset asserted right after a repeat pulse, button kept held throughout
    foreach (rst_pre[i]) run_vec(rst_pre[i], 200 + i);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 300, 0, {22'd0, db_level, press_tick, release_tick, long_tick, repeat_tick}, 32'd0);
    for (int unsigned e = 1; e <= 3; e++) begin
      tick();
      chk("rst_hold", 300, e, {22'd0, db_level, press_tick, release_tick, long_tick, repeat_tick}, 32'd0);
    end
    rst_n    = 1'b1;
    prev_lvl = 2'b00;
    foreach (rst_post[i]) run_vec(rst_post[i], 400 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
